// File: rtl/msg_event_decoder.sv
// Decodes ASCII command frames ("IFM-EU-#", "BDM-#", "END-#", ...) from a UART
// byte stream into one-cycle event pulses, a sticky stop flag and a frame count.
module msg_event_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ifm_eu,
    output logic       ifm_ru,
    output logic       ifm_cu,
    output logic       fim_eu,
    output logic       fim_ru,
    output logic       fim_cu,
    output logic       bdm,
    output logic       stop,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, C1, C2, D1, U1, U2, D2, TERM} state_t;

    state_t        state, state_n;
    logic [7:0]    code, code_n;
    logic [7:0]    unit, unit_n;
    logic [TW-1:0] timer;
    logic [6:0]    evt_q, evt_n;
    logic          end_n, err_n, ok, timeout_hit;

    assign timeout_hit = (state != IDLE) && !rx_valid && (timer == TIMER_MAX);

    always_comb begin
        state_n = state;
        code_n  = code;
        unit_n  = unit;
        evt_n   = '0;
        end_n   = 1'b0;
        err_n   = 1'b0;
        ok      = 1'b0;
        if (rx_valid) begin
            case (state)
                C1: begin
                    ok = (code == "I" && rx_data == "F") || (code == "F" && rx_data == "I") ||
                         (code == "B" && rx_data == "D") || (code == "E" && rx_data == "N");
                    state_n = C2;
                end
                C2: begin
                    ok = (code == "E") ? (rx_data == "D") : (rx_data == "M");
                    state_n = D1;
                end
                D1: begin
                    ok = (rx_data == "-");
                    state_n = (code == "I" || code == "F") ? U1 : TERM;
                end
                U1: begin
                    ok = (rx_data == "E" || rx_data == "R" || rx_data == "C");
                    unit_n  = rx_data;
                    state_n = U2;
                end
                U2: begin
                    ok = (rx_data == "U");
                    state_n = D2;
                end
                D2: begin
                    ok = (rx_data == "-");
                    state_n = TERM;
                end
                TERM: begin
                    ok = (rx_data == "#");
                    state_n = IDLE;
                    if (ok) begin
                        case (code)
                            "I": evt_n = (unit == "E") ? 7'b1000000 :
                                         (unit == "R") ? 7'b0100000 : 7'b0010000;
                            "F": evt_n = (unit == "E") ? 7'b0001000 :
                                         (unit == "R") ? 7'b0000100 : 7'b0000010;
                            "B": evt_n = 7'b0000001;
                            default: end_n = 1'b1;
                        endcase
                    end
                end
                default: ok = 1'b0;
            endcase
            // A rejected byte is treated as if it arrived in IDLE, so it may start a new frame.
            if (state == IDLE || !ok) begin
                err_n  = (state != IDLE);
                unit_n = unit;
                if (rx_data == "I" || rx_data == "F" || rx_data == "B" || rx_data == "E") begin
                    state_n = C1;
                    code_n  = rx_data;
                end else begin
                    state_n = IDLE;
                end
            end
        end else if (timeout_hit) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= '0;
            unit      <= '0;
            timer     <= '0;
            evt_q     <= '0;
            frame_err <= 1'b0;
            stop      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            unit      <= unit_n;
            timer     <= (state == IDLE || rx_valid || timeout_hit) ? '0 : timer + 1'b1;
            evt_q     <= evt_n;
            frame_err <= err_n;
            stop      <= stop | end_n;
            if (evt_n != '0 || end_n)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign {ifm_eu, ifm_ru, ifm_cu, fim_eu, fim_ru, fim_cu, bdm} = evt_q;

endmodule

// File: tb/tb_msg_event_decoder.sv
// Scoreboard bench for msg_event_decoder: stimulus pushes expected pulses/counts,
// a negedge monitor pops and compares whenever the DUT shows a pulse or count change.
module tb_msg_event_decoder;

    localparam int T = 20;
    localparam logic [7:0] E_IFM_EU = 8'h80, E_IFM_RU = 8'h40, E_IFM_CU = 8'h20;
    localparam logic [7:0] E_FIM_EU = 8'h10, E_FIM_RU = 8'h08, E_FIM_CU = 8'h04;
    localparam logic [7:0] E_BDM = 8'h02, E_ERR = 8'h01, E_END = 8'h00;

    typedef struct {
        logic [7:0] pulses;
        logic [7:0] cnt;
        logic       stop;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       ifm_eu, ifm_ru, ifm_cu, fim_eu, fim_ru, fim_cu, bdm, stop, frame_err;
    logic [7:0] frame_cnt;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = '0;
    logic [7:0] prev_cnt = '0;
    logic [7:0] obs;
    exp_t       e;

    msg_event_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ifm_eu(ifm_eu), .ifm_ru(ifm_ru), .ifm_cu(ifm_cu),
        .fim_eu(fim_eu), .fim_ru(fim_ru), .fim_cu(fim_cu),
        .bdm(bdm), .stop(stop), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    assign obs = {ifm_eu, ifm_ru, ifm_cu, fim_eu, fim_ru, fim_cu, bdm, frame_err};

    function automatic void check_output(string name, logic [31:0] actual, logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endfunction

    // Monitor: every pulse or count change must match the next queued expectation.
    always @(negedge clock) begin
        if (rst_n && (obs != 8'h00 || frame_cnt != prev_cnt)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got pulses=%b cnt=%0d, required none", obs, frame_cnt);
            end else begin
                e = exp_q.pop_front();
                check_output("pulses", 32'(obs), 32'(e.pulses));
                check_output("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                check_output("stop", 32'(stop), 32'(e.stop));
            end
        end
        prev_cnt = frame_cnt;
    end

    task automatic push_frame(logic [7:0] pulses, logic stop_exp);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back('{pulses: pulses, cnt: exp_cnt, stop: stop_exp});
    endtask

    task automatic push_err(logic stop_exp);
        exp_q.push_back('{pulses: E_ERR, cnt: exp_cnt, stop: stop_exp});
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_stimulus(logic [7:0] b, int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_str(string s, int gap);
        for (int i = 0; i < s.len(); i++)
            apply_stimulus(s[i], gap);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #2;
        check_output("reset_cnt", 32'(frame_cnt), 32'd0);
        check_output("reset_stop", 32'(stop), 32'd0);
        check_output("reset_pulses", 32'(obs), 32'd0);
        check_output("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clock);
        #2;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        apply_reset();

        push_frame(E_FIM_RU, 1'b0);
        send_str("FIM-RU-#", 9);
        idle(5);
        apply_reset();

        push_err(1'b0);
        push_frame(E_IFM_CU, 1'b0);
        send_str("IFM-XU-#IFM-CU-#", 0);
        idle(3);
        check_output("cnt_after_mismatch", 32'(frame_cnt), 32'd1);
        apply_reset();

        push_frame(E_BDM, 1'b0);
        push_frame(E_END, 1'b1);
        send_str("BDM-#END-#", 0);
        idle(4);
        push_frame(E_END, 1'b1);
        push_frame(E_FIM_CU, 1'b1);
        send_str("END-#FIM-CU-#", 0);
        idle(3);
        check_output("stop_sticky", 32'(stop), 32'd1);
        check_output("cnt_after_end", 32'(frame_cnt), 32'd4);
        apply_reset();

        // Idle gap one short of the limit must not time out.
        push_frame(E_IFM_EU, 1'b0);
        send_str("IFM-E", 0);
        idle(T - 1);
        send_str("U-#", 0);
        idle(3);
        push_err(1'b0);
        send_str("IFM-E", 0);
        idle(T + 5);
        push_frame(E_IFM_EU, 1'b0);
        send_str("IFM-EU-#", 0);
        idle(3);

        push_err(1'b0);
        push_frame(E_FIM_EU, 1'b0);
        send_str("FFIM-EU-#", 0);
        push_err(1'b0);
        push_frame(E_IFM_RU, 1'b0);
        send_str("IFM-RZIFM-RU-#", 0);
        idle(3);
        apply_reset();

        for (int k = 0; k < 256; k++) begin
            push_frame(E_BDM, 1'b0);
            send_str("BDM-#", 0);
        end
        idle(3);
        check_output("cnt_wrap", 32'(frame_cnt), 32'd0);
        apply_reset();

        send_str("END-", 0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        send_str("#", 0);
        idle(4);
        check_output("stop_after_reset", 32'(stop), 32'd0);
        check_output("cnt_after_reset", 32'(frame_cnt), 32'd0);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
